// File: rtl/warp_barrier_unit.sv
// Barrier arrival tracker: holds arriving warps stalled per barrier slot and
// hands the complete warp mask to the scheduler once the last participant arrives.
module warp_barrier_unit #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NW_BITS      = $clog2(NUM_WARPS),
    parameter int NB_BITS      = $clog2(NUM_BARRIERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [NB_BITS-1:0]   req_id,
    input  logic [NW_BITS-1:0]   req_size_m1,
    input  logic [NW_BITS-1:0]   req_wid,
    output logic                 req_ready,
    output logic                 rel_valid,
    output logic [NB_BITS-1:0]   rel_id,
    output logic [NUM_WARPS-1:0] rel_wmask,
    input  logic                 rel_ready,
    output logic [NUM_WARPS-1:0] stalled_wmask,
    output logic                 err_dup
);

    typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [NB_BITS-1:0]   rel_id_reg;
    logic [NUM_WARPS-1:0] rel_wmask_reg;
    logic                 err_dup_reg;

    logic [NUM_WARPS-1:0] mask_arr  [NUM_BARRIERS];
    logic [NW_BITS-1:0]   count_arr [NUM_BARRIERS];

    logic                 accept;
    logic                 is_dup;
    logic                 is_final;
    logic                 is_step;
    logic [NUM_WARPS-1:0] wid_bit;

    assign accept   = req_valid && req_ready;
    assign wid_bit  = {{(NUM_WARPS-1){1'b0}}, 1'b1} << req_wid;
    assign is_dup   = accept && ((stalled_wmask & wid_bit) != '0);
    // Final test uses this request's size_m1, not a value latched at the first arrival.
    assign is_final = accept && !is_dup && (count_arr[req_id] == req_size_m1);
    assign is_step  = accept && !is_dup && (count_arr[req_id] != req_size_m1);

    generate
        for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_bar
            logic [NUM_WARPS-1:0] mask_reg;
            logic [NW_BITS-1:0]   count_reg;
            logic                 hit;

            assign hit           = (req_id == NB_BITS'(gi));
            assign mask_arr[gi]  = mask_reg;
            assign count_arr[gi] = count_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    mask_reg  <= '0;
                    count_reg <= '0;
                end else if (hit && is_final) begin
                    mask_reg  <= '0;
                    count_reg <= '0;
                end else if (hit && is_step) begin
                    mask_reg  <= mask_reg | wid_bit;
                    count_reg <= count_reg + NW_BITS'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (is_final)  state_next = ST_PEND;
            ST_PEND: if (rel_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rel_valid = (state_reg == ST_PEND);
        req_ready = (state_reg != ST_PEND);
    end

    // Release payload is captured only on a final arrival, so it holds through PEND.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rel_id_reg    <= '0;
            rel_wmask_reg <= '0;
            err_dup_reg   <= 1'b0;
        end else begin
            err_dup_reg <= is_dup;
            if (is_final) begin
                rel_id_reg    <= req_id;
                rel_wmask_reg <= mask_arr[req_id] | wid_bit;
            end
        end
    end

    assign rel_id    = rel_id_reg;
    assign rel_wmask = rel_wmask_reg;
    assign err_dup   = err_dup_reg;

    always_comb begin
        stalled_wmask = rel_valid ? rel_wmask_reg : '0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            stalled_wmask = stalled_wmask | mask_arr[i];
        end
    end

endmodule

// File: tb/tb_warp_barrier_unit.sv
// Directed bench for warp_barrier_unit; expected releases are queued when the
// final arrival is driven and matched when the scheduler handshake occurs.
module tb_warp_barrier_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_id;
    logic [1:0] req_size_m1;
    logic [1:0] req_wid;
    logic       req_ready;
    logic       rel_valid;
    logic [1:0] rel_id;
    logic [3:0] rel_wmask;
    logic       rel_ready;
    logic [3:0] stalled_wmask;
    logic       err_dup;

    typedef struct {
        logic [1:0] id;
        logic [3:0] mask;
    } rel_t;

    rel_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    warp_barrier_unit #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_id        (req_id),
        .req_size_m1   (req_size_m1),
        .req_wid       (req_wid),
        .req_ready     (req_ready),
        .rel_valid     (rel_valid),
        .rel_id        (rel_id),
        .rel_wmask     (rel_wmask),
        .rel_ready     (rel_ready),
        .stalled_wmask (stalled_wmask),
        .err_dup       (err_dup)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive(input int id, input int size_m1, input int wid);
        req_valid   = 1'b1;
        req_id      = 2'(id);
        req_size_m1 = 2'(size_m1);
        req_wid     = 2'(wid);
    endtask

    task automatic expect_rel(input int id, input int mask);
        rel_t r;
        r.id   = 2'(id);
        r.mask = 4'(mask);
        exp_q.push_back(r);
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    // Scoreboard side: every completed release handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && rel_valid && rel_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_release", {30'd0, rel_id}, 32'hFFFF_FFFF);
            end else begin
                rel_t r;
                r = exp_q.pop_front();
                check("rel_id", {30'd0, rel_id}, {30'd0, r.id});
                check("rel_wmask", {28'd0, rel_wmask}, {28'd0, r.mask});
            end
        end
    end

    initial begin
        reset = 1'b0; rel_ready = 1'b1;
        req_valid = 1'b0; req_id = '0; req_size_m1 = '0; req_wid = '0;
        tick(); tick();
        reset = 1'b1;
        check("rst_rel_valid", {31'd0, rel_valid}, 0);
        check("rst_rel_id", {30'd0, rel_id}, 0);
        check("rst_rel_wmask", {28'd0, rel_wmask}, 0);
        check("rst_stalled", {28'd0, stalled_wmask}, 0);
        check("rst_err_dup", {31'd0, err_dup}, 0);
        check("rst_req_ready", {31'd0, req_ready}, 1);

        // Three-warp barrier at id 1.
        arrive(1, 2, 0); tick();
        check("t1_stalled_a", {28'd0, stalled_wmask}, 4'b0001);
        arrive(1, 2, 2); tick();
        check("t1_stalled_b", {28'd0, stalled_wmask}, 4'b0101);
        check("t1_no_rel", {31'd0, rel_valid}, 0);
        arrive(1, 2, 3); expect_rel(1, 4'b1101); tick();
        check("t1_rel_valid", {31'd0, rel_valid}, 1);
        check("t1_rel_id", {30'd0, rel_id}, 1);
        check("t1_rel_wmask", {28'd0, rel_wmask}, 4'b1101);
        check("t1_stalled_c", {28'd0, stalled_wmask}, 4'b1101);
        check("t1_req_ready", {31'd0, req_ready}, 0);
        idle(); tick();
        check("t1_after_valid", {31'd0, rel_valid}, 0);
        check("t1_after_stalled", {28'd0, stalled_wmask}, 0);

        // Single-warp barrier; then prove count[2] stayed 0.
        arrive(2, 0, 1); expect_rel(2, 4'b0010); tick();
        check("t2_rel_valid", {31'd0, rel_valid}, 1);
        check("t2_rel_wmask", {28'd0, rel_wmask}, 4'b0010);
        idle(); tick();
        arrive(2, 1, 1); tick();
        check("t2_count_clear", {31'd0, rel_valid}, 0);
        check("t2_stalled", {28'd0, stalled_wmask}, 4'b0010);
        arrive(2, 1, 0); expect_rel(2, 4'b0011); tick();
        check("t2_rel2_valid", {31'd0, rel_valid}, 1);
        idle(); tick();

        // Back-pressure from the scheduler for five cycles.
        rel_ready = 1'b0;
        arrive(0, 0, 3); expect_rel(0, 4'b1000); tick();
        arrive(1, 0, 2);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", {31'd0, rel_valid}, 1);
            check("t3_hold_id", {30'd0, rel_id}, 0);
            check("t3_hold_mask", {28'd0, rel_wmask}, 4'b1000);
            check("t3_req_ready", {31'd0, req_ready}, 0);
            tick();
        end
        idle(); rel_ready = 1'b1; tick();
        check("t3_done_valid", {31'd0, rel_valid}, 0);
        check("t3_done_ready", {31'd0, req_ready}, 1);
        check("t3_done_stalled", {28'd0, stalled_wmask}, 0);

        // Duplicate arrival of an already stalled warp.
        arrive(0, 1, 0); tick();
        arrive(3, 0, 0); tick();
        check("t4_err_dup", {31'd0, err_dup}, 1);
        check("t4_stalled", {28'd0, stalled_wmask}, 4'b0001);
        check("t4_no_rel", {31'd0, rel_valid}, 0);
        idle(); tick();
        check("t4_err_clear", {31'd0, err_dup}, 0);
        arrive(3, 0, 1); expect_rel(3, 4'b0010); tick();
        check("t4_b3_clean", {31'd0, rel_valid}, 1);
        idle(); tick();
        arrive(0, 1, 1); expect_rel(0, 4'b0011); tick();
        idle(); tick();

        // Interleaved independent barriers.
        arrive(0, 1, 0); tick();
        arrive(1, 1, 2); tick();
        check("t5_stalled", {28'd0, stalled_wmask}, 4'b0101);
        arrive(0, 1, 1); expect_rel(0, 4'b0011); tick();
        check("t5_rel0_valid", {31'd0, rel_valid}, 1);
        check("t5_rel0_mask", {28'd0, rel_wmask}, 4'b0011);
        idle(); tick();
        arrive(1, 1, 3); expect_rel(1, 4'b1100); tick();
        check("t5_rel1_valid", {31'd0, rel_valid}, 1);
        check("t5_rel1_mask", {28'd0, rel_wmask}, 4'b1100);
        idle(); tick();

        // Reset with a partially filled barrier.
        arrive(1, 3, 0); tick();
        arrive(1, 3, 1); tick();
        check("t6_pre_stalled", {28'd0, stalled_wmask}, 4'b0011);
        idle(); reset = 1'b0; tick();
        reset = 1'b1;
        check("t6_rst_stalled", {28'd0, stalled_wmask}, 0);
        check("t6_rst_valid", {31'd0, rel_valid}, 0);
        check("t6_rst_mask", {28'd0, rel_wmask}, 0);
        arrive(1, 1, 2); tick();
        check("t6_first_norel", {31'd0, rel_valid}, 0);
        check("t6_first_stalled", {28'd0, stalled_wmask}, 4'b0100);
        arrive(1, 1, 3); expect_rel(1, 4'b1100); tick();
        check("t6_rel_valid", {31'd0, rel_valid}, 1);
        check("t6_rel_mask", {28'd0, rel_wmask}, 4'b1100);
        idle(); tick(); tick();

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
